shift_8x64_unload: RTL and testbench

SHIFT_8X64_UNLOAD -- requirements
Module: shift_8x64_unload

---
 rtl/shift_8x64_pkg.sv | 19 +
 rtl/shift_8x64_mem.sv | 32 +++
 rtl/shift_8x64_unload.sv | 137 +++++++++++++
 tb/tb_shift_8x64_unload.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_8x64_pkg.sv
// Shared defaults and types for the shift_8x64 frame buffer.
//   WIDTH_DEF       : byte width of each entry
//   DEPTH_DEF       : entries per frame (power of two)
//   TAP_SPACING_DEF : distance between tap markers (divides DEPTH)
//   PTR_W           : pointer width for the default depth
//   state_t         : FILL accepts a frame, DRAIN unloads it
package shift_8x64_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int DEPTH_DEF       = 64;
    localparam int TAP_SPACING_DEF = 16;
    localparam int PTR_W           = $clog2(DEPTH_DEF);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/shift_8x64_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module shift_8x64_mem
    import shift_8x64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/shift_8x64_unload.sv
// Frame buffer: collects DEPTH bytes in FILL, then unloads them in DRAIN
// with a valid/ready handshake, marking tap and last positions.
// Optional feature: define SHIFT_UNLOAD_REVERSE_EN to drain the frame
// last-written byte first (taps/last mirrored accordingly).
//   clk, rst  : clock, synchronous active-high reset
//   in_valid / in_ready / in_data   : upstream byte stream
//   flush     : abort current frame, back to empty FILL
//   out_valid / out_ready / out_data : downstream byte stream
//   out_tap   : current output index is a tap position
//   out_last  : current output is the final byte of the frame
//   busy      : high while draining
module shift_8x64_unload
    import shift_8x64_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int TAP_SPACING = TAP_SPACING_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_tap,
    output logic             out_last,
    output logic             busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
    // TAP_SPACING divides a power-of-two DEPTH, so it is itself a power
    // of two and the in-group offset is just the low pointer bits.
    localparam logic [AW-1:0] TAP_MASK = AW'(TAP_SPACING - 1);

`ifdef SHIFT_UNLOAD_REVERSE_EN
    localparam bit            REVERSE  = 1'b1;
    localparam logic [AW-1:0] RD_START = PTR_MAX;
    localparam logic [AW-1:0] RD_LAST  = '0;
    localparam logic [AW-1:0] RD_TAP   = '0;
`else
    localparam bit            REVERSE  = 1'b0;
    localparam logic [AW-1:0] RD_START = '0;
    localparam logic [AW-1:0] RD_LAST  = PTR_MAX;
    localparam logic [AW-1:0] RD_TAP   = TAP_MASK;
`endif

    state_t           state, state_nxt;
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic             we;
    logic [WIDTH-1:0] rd_data;

    shift_8x64_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_data   = '0;
        out_tap    = 1'b0;
        out_last   = 1'b0;
        we         = 1'b0;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    // Reset also blocks the write so an aborted cycle
                    // leaves the array exactly as it was.
                    we         = !rst;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    if (wr_ptr == PTR_MAX) begin
                        state_nxt  = DRAIN;
                        rd_ptr_nxt = RD_START;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = rd_data;
                out_tap   = (rd_ptr & TAP_MASK) == RD_TAP;
                out_last  = rd_ptr == RD_LAST;
                if (out_ready && !flush) begin
                    if (rd_ptr == RD_LAST) begin
                        state_nxt  = FILL;
                        wr_ptr_nxt = '0;
                        rd_ptr_nxt = '0;
                    end else if (REVERSE) begin
                        rd_ptr_nxt = rd_ptr - 1'b1;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase

        // Flush overrides any handshake in the same cycle.
        if (flush) begin
            state_nxt  = FILL;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end
    end

endmodule

// File: tb/tb_shift_8x64_unload.sv
module tb_shift_8x64_unload;

    localparam int W     = 8;
    localparam int DEPTH = 64;
    localparam int TAP   = 16;
`ifdef SHIFT_UNLOAD_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_tap;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    shift_8x64_unload dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tap   (out_tap),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] fill_q[$];
    logic [W-1:0] drain_q[$];
    bit           m_drain = 0;
    int           popped  = 0;
    bit           chk_en  = 0;

    // DUT-observed handshakes for scenario-level checks
    logic [W-1:0] rec_d[$];
    bit           rec_tap[$];
    bit           rec_last[$];

    bit           prev_stall = 0;
    logic [W-1:0] prev_d;
    bit           prev_tap, prev_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after posedge; at negedge they hold the values the
    // next edge will sample, and outputs reflect the state after the last edge.
    always @(negedge clk) begin
        int idx;
        logic [W-1:0] e_d;
        bit e_tap, e_last;
        if (chk_en) begin
            idx    = REV ? (DEPTH - 1 - popped) : popped;
            e_d    = m_drain ? drain_q[0] : '0;
            e_tap  = m_drain && (REV ? (idx % TAP == 0) : (idx % TAP == TAP - 1));
            e_last = m_drain && (drain_q.size() == 1);
            chk("in_ready",  int'(in_ready),  int'(!m_drain));
            chk("out_valid", int'(out_valid), int'(m_drain));
            chk("busy",      int'(busy),      int'(m_drain));
            chk("out_data",  int'(out_data),  int'(e_d));
            chk("out_tap",   int'(out_tap),   int'(e_tap));
            chk("out_last",  int'(out_last),  int'(e_last));
            if (prev_stall) begin
                chk("stall_data", int'(out_data), int'(prev_d));
                chk("stall_tap",  int'(out_tap),  int'(prev_tap));
                chk("stall_last", int'(out_last), int'(prev_last));
            end
        end
        prev_stall = out_valid && !out_ready && !rst && !flush;
        prev_d = out_data; prev_tap = out_tap; prev_last = out_last;

        if (rst) begin
            fill_q.delete(); drain_q.delete(); m_drain = 0; popped = 0; chk_en = 1;
            prev_stall = 0;
        end else if (flush) begin
            fill_q.delete(); drain_q.delete(); m_drain = 0; popped = 0;
            prev_stall = 0;
        end else if (!m_drain) begin
            if (in_valid) begin
                fill_q.push_back(in_data);
                if (fill_q.size() == DEPTH) begin
                    drain_q.delete();
                    for (int i = 0; i < DEPTH; i++)
                        drain_q.push_back(REV ? fill_q[DEPTH-1-i] : fill_q[i]);
                    fill_q.delete();
                    m_drain = 1;
                    popped  = 0;
                end
            end
        end else if (out_ready) begin
            rec_d.push_back(out_data);
            rec_tap.push_back(out_tap);
            rec_last.push_back(out_last);
            void'(drain_q.pop_front());
            popped++;
            if (drain_q.size() == 0) m_drain = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offers one byte and holds until accepted; leaves in_valid high.
    task automatic push_byte(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 500) begin tick(); t++; end
        if (t >= 500) begin
            errors++; checks++;
            $display("FAIL push_timeout: in_ready stuck low, expected high");
        end
        tick();
    endtask

    // Runs until n output handshakes occur, out_ready at duty percent.
    task automatic drain_n(input int n, input int duty);
        int cnt = 0, t = 0;
        bit hs;
        while (cnt < n && t < 5000) begin
            out_ready = ($urandom_range(99) < duty);
            hs = out_valid && out_ready;
            tick();
            if (hs) cnt++;
            t++;
        end
        out_ready = 1'b0;
        if (cnt < n) begin
            errors++; checks++;
            $display("FAIL drain_timeout: got %0d handshakes expected %0d", cnt, n);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] base, input bit rnd_gap);
        for (int i = 0; i < DEPTH; i++) begin
            if (rnd_gap && $urandom_range(3) == 0) begin in_valid = 1'b0; tick(); end
            push_byte(base + W'(i));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_taps[4];
        logic [W-1:0] got_taps[$];
        logic [W-1:0] first;
        int last_cnt;

        // reset
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_out_data",  int'(out_data),  0);

        // 1: 0x00..0x3F back-to-back, full-rate drain
        rec_d.delete(); rec_tap.delete(); rec_last.delete();
        for (int i = 0; i < DEPTH - 1; i++) push_byte(W'(i));
        chk("pre_full_valid", int'(out_valid), 0);
        push_byte(8'h3F);
        in_valid = 1'b0;
        chk("lat1_valid", int'(out_valid), 1);
        chk("lat1_data",  int'(out_data),  REV ? 8'h3F : 8'h00);
        drain_n(DEPTH, 100);
        tick();
        chk("s1_count", rec_d.size(), DEPTH);
        got_taps.delete(); last_cnt = 0;
        for (int i = 0; i < rec_d.size(); i++) begin
            chk("s1_data", int'(rec_d[i]), REV ? 63 - i : i);
            if (rec_tap[i]) got_taps.push_back(rec_d[i]);
            if (rec_last[i]) begin
                last_cnt++;
                chk("s1_last_byte", int'(rec_d[i]), REV ? 8'h00 : 8'h3F);
            end
        end
        if (REV) exp_taps = '{8'h30, 8'h20, 8'h10, 8'h00};
        else     exp_taps = '{8'h0F, 8'h1F, 8'h2F, 8'h3F};
        chk("s1_tap_count", got_taps.size(), 4);
        for (int i = 0; i < 4 && i < got_taps.size(); i++)
            chk("s1_tap_byte", int'(got_taps[i]), int'(exp_taps[i]));
        chk("s1_last_count", last_cnt, 1);
        chk("s1_back_to_fill", int'(in_ready), 1);

        // 2: random data with gaps, 30% out_ready
        for (int f = 0; f < 2; f++) begin
            rec_d.delete();
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(3) == 0) begin in_valid = 1'b0; tick(); end
                push_byte(W'($urandom));
            end
            in_valid = 1'b0;
            drain_n(DEPTH, 30);
            tick();
            chk("s2_count", rec_d.size(), DEPTH);
        end

        // 3: flush after 20 bytes, then fresh frame 0xA0+
        for (int i = 0; i < 20; i++) push_byte(8'h55 + W'(i));
        in_valid = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        rec_d.delete();
        push_frame(8'hA0, 1'b0);
        drain_n(DEPTH, 60);
        tick();
        first = rec_d.size() > 0 ? rec_d[0] : 8'hxx;
        chk("s3_first", int'(first), REV ? 8'hDF : 8'hA0);

        // 4: reset in DRAIN after 10 reads
        push_frame(8'h10, 1'b1);
        drain_n(10, 100);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("s4_valid", int'(out_valid), 0);
        chk("s4_ready", int'(in_ready),  1);
        rec_d.delete();
        push_frame(8'h40, 1'b0);
        drain_n(DEPTH, 50);
        tick();
        first = rec_d.size() > 0 ? rec_d[0] : 8'hxx;
        chk("s4_first", int'(first), REV ? 8'h7F : 8'h40);

        // 5: flush on the 64th in-handshake
        for (int i = 0; i < DEPTH - 1; i++) push_byte(W'(i));
        in_data = 8'h3F; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("s5_valid", int'(out_valid), 0);
        chk("s5_ready", int'(in_ready),  1);
        tick();
        chk("s5_valid2", int'(out_valid), 0);
        rec_d.delete();
        push_frame(8'hC0, 1'b1);
        drain_n(DEPTH, 30);
        tick();
        first = rec_d.size() > 0 ? rec_d[0] : 8'hxx;
        chk("s5_first", int'(first), REV ? 8'hFF : 8'hC0);

        // 6: flush mid-DRAIN with out_ready high
        push_frame(8'h01, 1'b0);
        drain_n(5, 100);
        out_ready = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; out_ready = 1'b0;
        chk("s6_valid", int'(out_valid), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
